// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, execution-unit FSM states and flag layout.
// Also imported by alu_control, so opcode values must not drift.
package alu_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned OP_W     = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_MOVZ = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_ORR  = 4'b0100,
        OP_EOR  = 4'b0101,
        OP_CMP  = 4'b0110,
        OP_CBZ  = 4'b0111,
        OP_MUL  = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MUL_BUSY = 2'b01,
        ST_DONE     = 2'b10
    } alu_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bus of the ALU execution unit; slave side is the unit itself.
interface alu_exec_if
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [15:0]     imm16;
    logic [1:0]      hw;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            wb_en;
    logic            branch_taken;
    logic [3:0]      flags;
    logic            illegal_op;

    modport slave (
        input  in_valid, alu_op, op_a, op_b, imm16, hw, out_ready,
        output in_ready, out_valid, result, wb_en, branch_taken, flags, illegal_op
    );

    modport master (
        output in_valid, alu_op, op_a, op_b, imm16, hw, out_ready,
        input  in_ready, out_valid, result, wb_en, branch_taken, flags, illegal_op
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, XLEN cycles, low XLEN product bits.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_c,
    output logic [XLEN-1:0] product_c
);
    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  acc_q, mcand_q, mplier_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_c    = busy_q && (cnt_q == CNT_W'(XLEN - 1));
    assign busy_o    = busy_q;
    // Product including the final partial sum, so it is valid in the done cycle.
    assign product_c = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_c) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle logic/arith ops, iterative MUL, NZCV register,
// valid/ready on both sides with results held in DONE until consumed.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input logic       clk,
    input logic       rst_n,
    alu_exec_if.slave bus
);
    alu_state_e      state_q, state_d;
    logic            in_ready_q, out_valid_q;
    logic [XLEN-1:0] result_q, result_d;
    logic            wb_en_q, wb_en_d;
    logic            branch_q, branch_d;
    logic            illegal_q, illegal_d;
    nzcv_t           flags_q, flags_d;

    logic            accept, mul_start, mul_busy, mul_done;
    logic [XLEN-1:0] sum, diff, movz, product;
    nzcv_t           cmp_flags;

    assign accept    = bus.in_valid && in_ready_q;
    assign mul_start = accept && (bus.alu_op == OP_MUL);

    // Operation results evaluated from the operands being captured this edge.
    assign sum  = bus.op_a + bus.op_b;
    assign diff = bus.op_a - bus.op_b;
    assign movz = (32'(bus.hw) < XLEN / 16) ? (XLEN'(bus.imm16) << {bus.hw, 4'b0000}) : '0;
    assign cmp_flags = '{n: diff[XLEN-1],
                         z: (diff == '0),
                         c: (bus.op_a >= bus.op_b),
                         v: (bus.op_a[XLEN-1] != bus.op_b[XLEN-1]) && (diff[XLEN-1] != bus.op_a[XLEN-1])};

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (bus.op_a),
        .b_i       (bus.op_b),
        .busy_o    (mul_busy),
        .done_c    (mul_done),
        .product_c (product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        wb_en_d   = wb_en_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        flags_d   = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_DONE;
                    result_d  = '0;
                    wb_en_d   = 1'b0;
                    branch_d  = 1'b0;
                    illegal_d = 1'b0;
                    case (bus.alu_op)
                        OP_ADD:  begin result_d = sum;                   wb_en_d = 1'b1; end
                        OP_SUB:  begin result_d = diff;                  wb_en_d = 1'b1; end
                        OP_AND:  begin result_d = bus.op_a & bus.op_b;   wb_en_d = 1'b1; end
                        OP_ORR:  begin result_d = bus.op_a | bus.op_b;   wb_en_d = 1'b1; end
                        OP_EOR:  begin result_d = bus.op_a ^ bus.op_b;   wb_en_d = 1'b1; end
                        OP_MOVZ: begin result_d = movz;                  wb_en_d = 1'b1; end
                        OP_CMP:  begin result_d = diff;                  flags_d = cmp_flags; end
                        OP_CBZ:  branch_d = (bus.op_a == '0);
                        OP_MUL:  begin state_d = ST_MUL_BUSY;            wb_en_d = 1'b1; end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            ST_MUL_BUSY: begin
                if (mul_busy && mul_done) begin
                    result_d = product;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wb_en_q     <= 1'b0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            result_q    <= result_d;
            wb_en_q     <= wb_en_d;
            branch_q    <= branch_d;
            illegal_q   <= illegal_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.wb_en        = wb_en_q;
    assign bus.branch_taken = branch_q;
    assign bus.illegal_op   = illegal_q;
    assign bus.flags        = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec: hand-computed results, latencies, hold and reset behaviour.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    logic [63:0] r_res;
    logic        r_wb, r_br, r_ill;
    logic [3:0]  r_flags;
    int          r_lat;
    int          r_busy_rdy;

    alu_exec_if #(.XLEN(64)) bus ();

    alu_exec #(.XLEN(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for out_valid, capture outputs, then complete the handshake.
    task automatic exec_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [15:0] imm, input logic [1:0] hw);
        bit seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.imm16    = imm;
        bus.hw       = hw;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = ~a;
        bus.op_b     = ~b;
        bus.imm16    = ~imm;
        r_lat      = 0;
        r_busy_rdy = 0;
        seen       = 1'b0;
        while (!seen && r_lat < 200) begin
            @(negedge clk);
            r_lat++;
            if (bus.out_valid) seen = 1'b1;
            else if (bus.in_ready) r_busy_rdy++;
        end
        r_res   = bus.result;
        r_wb    = bus.wb_en;
        r_br    = bus.branch_taken;
        r_ill   = bus.illegal_op;
        r_flags = bus.flags;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int vhigh;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.imm16     = '0;
        bus.hw        = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_outs", {61'd0, bus.wb_en, bus.branch_taken, bus.illegal_op}, 64'd0);

        // out_ready with nothing pending changes nothing
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ordy_valid", 64'(bus.out_valid), 64'd0);
        chk("idle_ordy_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;

        exec_op(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 16'd0, 2'd0);
        chk("add_wrap_res", r_res, 64'd0);
        chk("add_wrap_lat", 64'(r_lat), 64'd1);
        chk("add_wrap_misc", {59'd0, r_wb, r_br, r_ill, 2'b00}, 64'b10000);
        chk("add_wrap_flags", 64'(r_flags), 64'd0);
        @(negedge clk);
        chk("post_hs_ready", 64'(bus.in_ready), 64'd1);
        chk("post_hs_valid", 64'(bus.out_valid), 64'd0);

        exec_op(OP_CMP, 64'd5, 64'd7, 16'd0, 2'd0);
        chk("cmp57_wb", 64'(r_wb), 64'd0);
        chk("cmp57_flags", 64'(r_flags), 64'b1000);

        exec_op(OP_ADD, 64'd3, 64'd4, 16'd0, 2'd0);
        chk("add34_res", r_res, 64'd7);
        chk("add34_flags_kept", 64'(r_flags), 64'b1000);

        exec_op(OP_CMP, 64'h8000_0000_0000_0000, 64'd1, 16'd0, 2'd0);
        chk("cmp_ovf_flags", 64'(r_flags), 64'b0011);

        exec_op(OP_SUB, 64'd5, 64'd7, 16'd0, 2'd0);
        chk("sub_res", r_res, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_wb_flags", {59'd0, r_wb, r_flags}, {59'd0, 1'b1, 4'b0011});

        exec_op(OP_AND, 64'hF0F0, 64'hFF00, 16'd0, 2'd0);
        chk("and_res", r_res, 64'hF000);
        exec_op(OP_ORR, 64'hF0F0, 64'hFF00, 16'd0, 2'd0);
        chk("orr_res", r_res, 64'hFFF0);
        exec_op(OP_EOR, 64'hF0F0, 64'hFF00, 16'd0, 2'd0);
        chk("eor_res", r_res, 64'h0FF0);

        exec_op(OP_MOVZ, 64'hDEAD, 64'hBEEF, 16'h1234, 2'd2);
        chk("movz_hw2", r_res, 64'h0000_1234_0000_0000);
        chk("movz_hw2_wb", 64'(r_wb), 64'd1);
        exec_op(OP_MOVZ, 64'd0, 64'd0, 16'h1234, 2'd3);
        chk("movz_hw3", r_res, 64'h1234_0000_0000_0000);
        exec_op(OP_MOVZ, 64'd0, 64'd0, 16'hABCD, 2'd0);
        chk("movz_hw0", r_res, 64'h0000_0000_0000_ABCD);

        exec_op(OP_CBZ, 64'd0, 64'd9, 16'd0, 2'd0);
        chk("cbz0_misc", {61'd0, r_wb, r_br, r_ill}, 64'b010);
        chk("cbz0_res", r_res, 64'd0);
        exec_op(OP_CBZ, 64'd3, 64'd0, 16'd0, 2'd0);
        chk("cbz3_br", 64'(r_br), 64'd0);

        exec_op(4'b1111, 64'd3, 64'd4, 16'd0, 2'd0);
        chk("ill_misc", {61'd0, r_wb, r_br, r_ill}, 64'b001);
        chk("ill_res", r_res, 64'd0);
        chk("ill_flags", 64'(r_flags), 64'b0011);
        chk("ill_lat", 64'(r_lat), 64'd1);

        exec_op(OP_MUL, 64'h1_0000_0001, 64'd3, 16'd0, 2'd0);
        chk("mul_res", r_res, 64'h3_0000_0003);
        chk("mul_lat", 64'(r_lat), 64'd65);
        chk("mul_busy_rdy", 64'(r_busy_rdy), 64'd0);
        chk("mul_wb", 64'(r_wb), 64'd1);
        exec_op(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 2'd0);
        chk("mul_neg1sq", r_res, 64'd1);
        exec_op(OP_MUL, 64'h0123_4567_89AB_CDEF, 64'h10, 16'd0, 2'd0);
        chk("mul_x16", r_res, 64'h1234_5678_9ABC_DEF0);

        // Hold in DONE with out_ready low; a competing request must be ignored
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = OP_ADD;
        bus.op_a     = 64'd10;
        bus.op_b     = 64'd20;
        @(posedge clk);
        #1;
        bus.op_a = 64'd1;
        bus.op_b = 64'd1;
        bus.alu_op = OP_CBZ;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_res", bus.result, 64'd30);
            chk("hold_misc", {61'd0, bus.wb_en, bus.branch_taken, bus.illegal_op}, 64'b100);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("hold_rel_ready", 64'(bus.in_ready), 64'd1);
        chk("hold_rel_valid", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = OP_MUL;
        bus.op_a     = 64'd7;
        bus.op_b     = 64'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("mulrst_busy", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mulrst_flags_now", 64'(bus.flags), 64'd0);
        chk("mulrst_valid_now", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vhigh = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.out_valid) vhigh++;
        end
        chk("mulrst_no_valid", 64'(vhigh), 64'd0);
        chk("mulrst_ready", 64'(bus.in_ready), 64'd1);
        chk("mulrst_flags", 64'(bus.flags), 64'd0);

        exec_op(OP_ADD, 64'd100, 64'd23, 16'd0, 2'd0);
        chk("post_rst_add", r_res, 64'd123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 alu_op  input  4  operation code as produced by alu_control.
REQ-007 op_a  input  XLEN  first operand (Xn / Xt).
REQ-008 op_b  input  XLEN  second operand (Xm or zero-extended immediate).
REQ-009 imm16  input  16  MOVZ immediate.
REQ-010 hw  input  2  MOVZ shift selector, shift = 16*hw.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  XLEN  computed value.
REQ-014 wb_en  output  1  result is to be written to a register.
REQ-015 branch_taken  output  1  CBZ condition true.
REQ-016 flags  output  4  architectural NZCV register {N,Z,C,V}.
REQ-017 illegal_op  output  1  alu_op was not a defined code.

Function
REQ-018 Codes SHALL be: 0000 ADD, 0001 MOVZ, 0010 SUB, 0011 AND, 0100 ORR, 0101 EOR, 0110 CMP, 0111 CBZ, 1000 MUL; all others illegal.
REQ-019 FSM SHALL have states IDLE, MUL_BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 Accept SHALL occur on a clock edge with in_valid && in_ready; operands and alu_op SHALL be captured at that edge.
REQ-021 Single-cycle ops (all except MUL) SHALL go IDLE->DONE, out_valid high in the cycle after accept.
REQ-022 MUL SHALL go IDLE->MUL_BUSY, shift-add one multiplier bit per cycle for XLEN cycles, then DONE; out_valid high XLEN+1 cycles after accept; result = low XLEN bits of product.
REQ-023 In DONE, result, wb_en, branch_taken, illegal_op SHALL hold stable until out_ready; on out_valid && out_ready the FSM SHALL return to IDLE.
REQ-024 ADD/SUB/AND/ORR/EOR SHALL wrap modulo 2^XLEN, wb_en=1, flags unchanged.
REQ-025 MOVZ SHALL give result = zero-extended imm16 << (16*hw), wb_en=1; hw beyond XLEN/16-1 SHALL give result 0.
REQ-026 CMP SHALL compute op_a-op_b, wb_en=0, and update flags on entry to DONE: N=msb, Z=(diff==0), C=no borrow (op_a>=op_b unsigned), V=signed overflow.
REQ-027 CBZ SHALL give branch_taken=(op_a==0), wb_en=0, result 0, flags unchanged.
REQ-028 Illegal code SHALL complete single-cycle with illegal_op=1, result 0, wb_en=0, flags unchanged.
REQ-029 branch_taken and illegal_op SHALL be 0 for every op other than CBZ and illegal respectively.
REQ-030 in_valid while not in IDLE SHALL be ignored (no capture, no effect).
REQ-031 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, flags 0000, result 0, out_valid 0, wb_en 0, branch_taken 0, illegal_op 0, in_ready 1 after deassertion.
REQ-033 Reset during MUL_BUSY or DONE SHALL abandon the operation with no flag update and no output pulse.
REQ-034 Reset deassertion SHALL be synchronised by the system; block assumes release away from the active clock edge.

Structure
REQ-035 alu_op code constants, state encoding and XLEN default SHALL live in shared package alu_pkg, also used by alu_control.
REQ-036 Iterative multiplier SHALL be sub-module alu_mul_iter (start, operands in; busy, done, product out).
REQ-037 Flag computation SHALL be combinational from the captured operands; only the NZCV register is stateful.

Verification
REQ-038 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result 0, wb_en=1, flags unchanged, out_valid 1 cycle after accept.
REQ-039 CMP a=5, b=7 -> wb_en=0, flags N=1 Z=0 C=0 V=0; CMP a=0x8000_0000_0000_0000, b=1 -> V=1, C=1, N=0.
REQ-040 MOVZ imm16=0x1234, hw=2 -> result 0x0000_1234_0000_0000; CBZ a=0 -> branch_taken=1, a=3 -> 0.
REQ-041 MUL a=0x1_0000_0001, b=3 -> result 0x3_0000_0003 exactly 65 cycles after accept; in_ready 0 throughout.
REQ-042 out_ready held low 5 cycles in DONE -> outputs stable, new in_valid ignored; then handshake -> IDLE next cycle.
REQ-043 rst_n pulsed low at MUL_BUSY cycle 30 -> out_valid never rises, flags 0000, in_ready 1 after release.
